// File: rtl/sound_i2s_tx.sv
// Philips I2S transmitter: latches one mixed PCM sample per frame and serialises it MSB first.
// Build option SOUND_I2S_STEREO_EN duplicates the sample into the right slot; otherwise the right slot is silent.
module sound_i2s_tx #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic                RESET_n,
    input  logic                CLK,
    input  logic [IN_WIDTH-1:0] IN_SIGNAL,
    input  logic                ENABLE,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                SDATA,
    output logic                SAMPLE_STROBE
);

    // state | meaning
    // IDLE  | outputs parked at 0, waiting for ENABLE
    // RUN   | serialising frames; leaves only at a frame boundary
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] OUT_POS  = CNT_W'(OUT_WIDTH);

    state_t                 state;
    logic [DIV_W-1:0]       div;
    logic [CNT_W-1:0]       bitcnt;
    logic [OUT_WIDTH-1:0]   left_word;
    logic [OUT_WIDTH-1:0]   right_word;
    logic [OUT_WIDTH-1:0]   conv_word;

    logic [CNT_W-1:0]       cnt_n;
    logic [CNT_W-1:0]       pos_n;
    logic                   right_n;
    logic [OUT_WIDTH-1:0]   sel_word;
    logic [OUT_WIDTH-1:0]   shifted;
    logic                   sdata_n;

    // Truncate LSBs when narrowing, zero-fill LSBs when widening.
    generate
        if (IN_WIDTH >= OUT_WIDTH) begin : g_narrow
            assign conv_word = OUT_WIDTH'(IN_SIGNAL >> (IN_WIDTH - OUT_WIDTH));
        end else begin : g_widen
            assign conv_word = OUT_WIDTH'(IN_SIGNAL) << (OUT_WIDTH - IN_WIDTH);
        end
    endgenerate

    // Next bit position; slot position 0 is the I2S one-bit MSB delay.
    always_comb begin
        cnt_n    = (bitcnt == CNT_LAST) ? '0 : bitcnt + CNT_W'(1);
        right_n  = (cnt_n >= SLOT_CNT);
        pos_n    = right_n ? (cnt_n - SLOT_CNT) : cnt_n;
        sel_word = right_n ? right_word : left_word;
        shifted  = '0;
        sdata_n  = 1'b0;
        if ((pos_n != '0) && (pos_n <= OUT_POS)) begin
            shifted = sel_word >> (OUT_POS - pos_n);
            sdata_n = shifted[0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= IDLE;
            div           <= '0;
            bitcnt        <= '0;
            left_word     <= '0;
            right_word    <= '0;
            BCLK          <= 1'b0;
            LRCLK         <= 1'b0;
            SDATA         <= 1'b0;
            SAMPLE_STROBE <= 1'b0;
        end else begin
            SAMPLE_STROBE <= 1'b0;
            case (state)
                IDLE: begin
                    div    <= '0;
                    bitcnt <= '0;
                    BCLK   <= 1'b0;
                    LRCLK  <= 1'b0;
                    SDATA  <= 1'b0;
                    if (ENABLE) begin
                        state         <= RUN;
                        left_word     <= conv_word;
`ifdef SOUND_I2S_STEREO_EN
                        right_word    <= conv_word;
`else
                        right_word    <= '0;
`endif
                        SAMPLE_STROBE <= 1'b1;
                    end
                end
                RUN: begin
                    if (div == DIV_LAST) begin
                        div  <= '0;
                        BCLK <= ~BCLK;
                        if (BCLK) begin
                            bitcnt <= cnt_n;
                            LRCLK  <= right_n;
                            SDATA  <= sdata_n;
                            if (bitcnt == CNT_LAST) begin
                                if (ENABLE) begin
                                    left_word     <= conv_word;
`ifdef SOUND_I2S_STEREO_EN
                                    right_word    <= conv_word;
`else
                                    right_word    <= '0;
`endif
                                    SAMPLE_STROBE <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Bench for sound_i2s_tx: three widths (16/12/20-bit input) run in lockstep against a frame-level model.
module tb_sound_i2s_tx;
    localparam int D     = 2;
    localparam int SLOT  = 32;
    localparam int FRAME = 4 * SLOT * D;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ENABLE = 1'b0;
    logic [15:0] in16 = 16'h0;
    logic [11:0] in12 = 12'h0;
    logic [19:0] in20 = 20'h0;
    logic [2:0]  bclk, lrclk, sdata, strobe;

    int checks = 0;
    int errors = 0;

    bit          run = 1'b0;
    int          n = 0;
    logic [15:0] wl [3];
    string       names [3] = '{"w16", "w12", "w20"};

    sound_i2s_tx #(.IN_WIDTH(16), .OUT_WIDTH(16), .SLOT_BITS(SLOT), .BCLK_DIV(D)) u_w16 (
        .RESET_n(RESET_n), .CLK(CLK), .IN_SIGNAL(in16), .ENABLE(ENABLE),
        .BCLK(bclk[0]), .LRCLK(lrclk[0]), .SDATA(sdata[0]), .SAMPLE_STROBE(strobe[0]));
    sound_i2s_tx #(.IN_WIDTH(12), .OUT_WIDTH(16), .SLOT_BITS(SLOT), .BCLK_DIV(D)) u_w12 (
        .RESET_n(RESET_n), .CLK(CLK), .IN_SIGNAL(in12), .ENABLE(ENABLE),
        .BCLK(bclk[1]), .LRCLK(lrclk[1]), .SDATA(sdata[1]), .SAMPLE_STROBE(strobe[1]));
    sound_i2s_tx #(.IN_WIDTH(20), .OUT_WIDTH(16), .SLOT_BITS(SLOT), .BCLK_DIV(D)) u_w20 (
        .RESET_n(RESET_n), .CLK(CLK), .IN_SIGNAL(in20), .ENABLE(ENABLE),
        .BCLK(bclk[2]), .LRCLK(lrclk[2]), .SDATA(sdata[2]), .SAMPLE_STROBE(strobe[2]));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got {bclk,lr,sd,stb}=%b expected %b", tag, $time, got, exp);
        end
    endtask

    // Expected outputs n CLK cycles after the latch edge of the current frame.
    function automatic logic [3:0] expv(input int cyc, input logic [15:0] left);
        logic [15:0] right, w, tmp;
        int   k, bc, p;
        logic lr, sd, bk;
`ifdef SOUND_I2S_STEREO_EN
        right = left;
`else
        right = 16'h0;
`endif
        k  = cyc / (2 * D);
        bc = k % (2 * SLOT);
        lr = (bc >= SLOT);
        p  = bc % SLOT;
        w  = lr ? right : left;
        sd = 1'b0;
        if (p >= 1 && p <= 16) begin
            tmp = w >> (16 - p);
            sd  = tmp[0];
        end
        bk = ((cyc / D) % 2) == 1;
        return {bk, lr, sd, cyc == 0};
    endfunction

    task automatic latch();
        wl[0] = in16;
        wl[1] = 16'(in12 * 16);
        wl[2] = 16'(in20 / 16);
    endtask

    task automatic compare();
        for (int i = 0; i < 3; i++)
            check($sformatf("%s n=%0d", names[i], n),
                  {bclk[i], lrclk[i], sdata[i], strobe[i]},
                  run ? expv(n, wl[i]) : 4'b0000);
    endtask

    task automatic step();
        @(posedge CLK);
        if (!RESET_n) begin
            run = 1'b0;
        end else if (!run) begin
            if (ENABLE) begin
                run = 1'b1;
                n   = 0;
                latch();
            end
        end else begin
            n++;
            if (n == FRAME) begin
                n = 0;
                if (ENABLE) latch();
                else        run = 1'b0;
            end
        end
        @(negedge CLK);
        compare();
    endtask

    task automatic step_until(input int target);
        for (int g = 0; g < 2 * FRAME; g++) begin
            step();
            if (run && n == target) return;
        end
        checks++;
        errors++;
        $display("FAIL step_until target=%0d never reached", target);
    endtask

    initial begin
        wl[0] = 16'h0; wl[1] = 16'h0; wl[2] = 16'h0;
        in16 = 16'h8001; in12 = 12'h800; in20 = 20'h12345;
        repeat (3) step();
        RESET_n = 1'b1;
        repeat (3) step();

        // First frame with fixed test vectors.
        ENABLE = 1'b1;
        repeat (FRAME) step();

        // Random samples changing every cycle; only boundary values matter.
        repeat (2 * FRAME) begin
            in16 = 16'($urandom);
            in12 = 12'($urandom);
            in20 = 20'($urandom);
            step();
        end

        // Mid-frame input change must not reach the current frame.
        in16 = 16'h1111; in12 = 12'h111; in20 = 20'h11111;
        step_until(0);
        step_until(100);
        in16 = 16'h2222; in12 = 12'h222; in20 = 20'h22222;
        step_until(0);

        // Drop ENABLE at bit 10: frame completes, then parks.
        step_until(10 * 2 * D);
        ENABLE = 1'b0;
        repeat (FRAME) step();

        // Restart, then reset mid-frame and restart again.
        ENABLE = 1'b1;
        in16 = 16'($urandom); in12 = 12'($urandom); in20 = 20'($urandom);
        repeat (90) step();
        RESET_n = 1'b0;
        run = 1'b0;
        #1;
        compare();
        repeat (3) step();
        RESET_n = 1'b1;
        repeat (FRAME + 40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
